// File: rtl/pixel_stream_source.sv
// Raster source: streams a preloaded frame memory as VSYNC/HSYNC-framed pixels.
// The frame memory is writable only while idle; rejected writes raise wr_err for one cycle.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// S_IDLE   | waiting for start; frame memory writable
// S_VS     | vertical blanking, VSYNC high for V_BLANK cycles
// S_ACTIVE | streaming one line; pause stalls without losing a pixel
// S_HBLANK | H_BLANK idle cycles after every line, including the last
// S_DONE   | one-cycle end-of-frame pulse
module pixel_stream_source #(
  parameter int dataWidth = 16,
  parameter int COLS      = 28,
  parameter int ROWS      = 28,
  parameter int H_BLANK   = 4,
  parameter int V_BLANK   = 8,
  // One spare code above the last word so out-of-range writes stay expressible
  // even when ROWS*COLS is a power of two.
  localparam int ADDR_W   = $clog2(ROWS*COLS+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [dataWidth-1:0] wr_data,
  output logic                 wr_err,
  input  logic                 start,
  input  logic                 pause,
  output logic                 VSYNC,
  output logic                 HSYNC,
  output logic [dataWidth-1:0] data_out,
  output logic                 busy,
  output logic                 done
);

  localparam int DEPTH     = ROWS*COLS;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W     = $clog2(COLS+1);
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BLANK_MAX = (V_BLANK > H_BLANK) ? V_BLANK : H_BLANK;
  localparam int CNT_W     = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VS,
    S_ACTIVE,
    S_HBLANK,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   vsync_q, vsync_d;
  logic                   hsync_q, hsync_d;
  logic [dataWidth-1:0]   data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_err_q, wr_err_d;
  logic                   emit;
  logic                   wr_ok;
  logic [dataWidth-1:0]   rd_data;

  logic [dataWidth-1:0]   mem [0:DEPTH-1];

  always_comb begin
    wr_ok    = wr_en && (state_q == S_IDLE) && (wr_addr < ADDR_W'(DEPTH));
    wr_err_d = wr_en && ((state_q != S_IDLE) || (wr_addr >= ADDR_W'(DEPTH)));
  end

  // Frame contents survive reset; only the write path is gated by it.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // addr_q always points at the next unsent pixel, so the read lands in data_q
  // on the same edge that raises HSYNC.
  always_comb begin
    rd_data = mem[addr_q[IDX_W-1:0]];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    vsync_d = 1'b0;
    hsync_d = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    emit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_VS;
          cnt_d   = CNT_W'(V_BLANK-1);
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          vsync_d = 1'b1;
        end
      end
      S_VS: begin
        if (cnt_q == '0) begin
          state_d = S_ACTIVE;
          emit    = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          vsync_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (col_q == COL_W'(COLS)) begin
          state_d = S_HBLANK;
          cnt_d   = CNT_W'(H_BLANK-1);
          col_d   = '0;
        end else if (!pause) begin
          emit = 1'b1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == '0) begin
          if (row_q == ROW_W'(ROWS-1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ACTIVE;
            row_d   = row_q + ROW_W'(1);
            emit    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (emit) begin
      hsync_d = 1'b1;
      data_d  = rd_data;
      addr_d  = addr_q + ADDR_W'(1);
      col_d   = col_q + COL_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      vsync_q  <= 1'b0;
      hsync_q  <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      vsync_q  <= vsync_d;
      hsync_q  <= hsync_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign VSYNC    = vsync_q;
  assign HSYNC    = hsync_q;
  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_err   = wr_err_q;

endmodule
